// File: rtl/noc_credit_rx_port.sv
// Receive end of the credit-based flit link: a DEPTH-entry flit FIFO with a
// valid/ready drain side and a registered one-cycle credit pulse per popped flit.
module noc_credit_rx_port #(
    parameter int DATA_W = 20,
    parameter int DEPTH  = 4
) (
    input  logic                       clk,
    input  logic                       RST,
    input  logic [DATA_W-1:0]          datain,
    input  logic                       in_valid,
    output logic [DATA_W-1:0]          dataout,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic                       co,
    output logic [$clog2(DEPTH+1)-1:0] level,
    output logic                       ovf_err
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH+1);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]     r_wp;
    logic [AW-1:0]     r_rp;
    logic [LW-1:0]     r_level;
    logic              r_co;
    logic              r_ovf;

    logic w_empty;
    logic w_full;
    logic w_pop;
    logic w_push;
    logic w_drop;

    assign w_empty = (r_level == '0);
    assign w_full  = (r_level == LW'(DEPTH));
    assign w_pop   = !w_empty && out_ready;
    // A full FIFO still accepts a flit when the head leaves in the same cycle.
    assign w_push  = in_valid && (!w_full || w_pop);
    assign w_drop  = in_valid && w_full && !w_pop;

    // Storage is not reset; only the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wp] <= datain;
    end

    always_ff @(posedge clk or negedge RST) begin
        if (!RST) begin
            r_wp    <= '0;
            r_rp    <= '0;
            r_level <= '0;
            r_co    <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            if (w_push) r_wp <= r_wp + AW'(1);
            if (w_pop)  r_rp <= r_rp + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + LW'(1);
                2'b01:   r_level <= r_level - LW'(1);
                default: r_level <= r_level;
            endcase
            r_co <= w_pop;
            if (w_drop) r_ovf <= 1'b1;
        end
    end

    assign out_valid = !w_empty;
    assign dataout   = out_valid ? r_mem[r_rp] : '0;
    assign level     = r_level;
    assign co        = r_co;
    assign ovf_err   = r_ovf;
endmodule

// File: tb/tb_noc_credit_rx_port.sv
// Directed bench for noc_credit_rx_port: reset, single flit, overflow,
// full push/pop, streaming with pointer wrap, and mid-operation reset.
module tb_noc_credit_rx_port;
    logic        clk = 1'b0;
    logic        RST = 1'b0;
    logic [19:0] datain = '0;
    logic        in_valid = 1'b0;
    logic [19:0] dataout;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic        co;
    logic [2:0]  level;
    logic        ovf_err;

    int n_vec = 0;
    int n_err = 0;

    noc_credit_rx_port #(.DATA_W(20), .DEPTH(4)) dut (
        .clk(clk), .RST(RST), .datain(datain), .in_valid(in_valid),
        .dataout(dataout), .out_valid(out_valid), .out_ready(out_ready),
        .co(co), .level(level), .ovf_err(ovf_err)
    );

    always #5 clk = ~clk;

    // Advance past the next rising edge; inputs are driven and outputs sampled here.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        RST       = 1'b0;
        step();
        RST = 1'b1;
        step();
    endtask

    task automatic test_reset();
        RST = 1'b0;
        for (int i = 0; i < 4; i++) begin
            datain    = 20'($urandom);
            in_valid  = 1'($urandom);
            out_ready = 1'($urandom);
            step();
            n_vec++;
            if ({dataout, out_valid, co, level, ovf_err} !== 26'd0) begin
                n_err++;
                $display("FAIL reset_hold: got dout=%h v=%b co=%b lvl=%0d ovf=%b exp all 0",
                         dataout, out_valid, co, level, ovf_err);
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        RST       = 1'b1;
        step();
        step();
        n_vec++;
        if ({dataout, out_valid, co, level, ovf_err} !== 26'd0) begin
            n_err++;
            $display("FAIL reset_release: got dout=%h v=%b co=%b lvl=%0d ovf=%b exp all 0",
                     dataout, out_valid, co, level, ovf_err);
        end
        out_ready = 1'b0;
    endtask

    task automatic test_single();
        do_reset();
        datain = 20'h12345; in_valid = 1'b1; out_ready = 1'b0;
        step();
        in_valid = 1'b0;
        n_vec++;
        if (out_valid !== 1'b1 || dataout !== 20'h12345 || level !== 3'd1 || co !== 1'b0) begin
            n_err++;
            $display("FAIL single_push: got v=%b dout=%h lvl=%0d co=%b exp v=1 dout=12345 lvl=1 co=0",
                     out_valid, dataout, level, co);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        n_vec++;
        if (out_valid !== 1'b0 || dataout !== 20'h0 || level !== 3'd0 || co !== 1'b1) begin
            n_err++;
            $display("FAIL single_pop: got v=%b dout=%h lvl=%0d co=%b exp v=0 dout=0 lvl=0 co=1",
                     out_valid, dataout, level, co);
        end
        step();
        n_vec++;
        if (co !== 1'b0) begin
            n_err++;
            $display("FAIL single_co_len: got co=%b exp 0", co);
        end
    endtask

    task automatic test_fill_ovf();
        do_reset();
        for (int i = 1; i <= 4; i++) begin
            datain = 20'(i); in_valid = 1'b1;
            step();
            n_vec++;
            if (level !== 3'(i) || co !== 1'b0 || ovf_err !== 1'b0) begin
                n_err++;
                $display("FAIL fill_%0d: got lvl=%0d co=%b ovf=%b exp lvl=%0d co=0 ovf=0",
                         i, level, co, ovf_err, i);
            end
        end
        datain = 20'h00005;
        step();
        in_valid = 1'b0;
        n_vec++;
        if (ovf_err !== 1'b1 || level !== 3'd4 || dataout !== 20'h00001) begin
            n_err++;
            $display("FAIL ovf_drop: got ovf=%b lvl=%0d head=%h exp ovf=1 lvl=4 head=00001",
                     ovf_err, level, dataout);
        end
        for (int i = 1; i <= 4; i++) begin
            n_vec++;
            if (out_valid !== 1'b1 || dataout !== 20'(i)) begin
                n_err++;
                $display("FAIL drain_data_%0d: got v=%b dout=%h exp v=1 dout=%h",
                         i, out_valid, dataout, 20'(i));
            end
            out_ready = 1'b1;
            step();
            n_vec++;
            if (co !== 1'b1) begin
                n_err++;
                $display("FAIL drain_co_%0d: got co=%b exp 1", i, co);
            end
        end
        out_ready = 1'b0;
        n_vec++;
        if (out_valid !== 1'b0 || level !== 3'd0 || ovf_err !== 1'b1) begin
            n_err++;
            $display("FAIL drain_end: got v=%b lvl=%0d ovf=%b exp v=0 lvl=0 ovf=1",
                     out_valid, level, ovf_err);
        end
        step();
        n_vec++;
        if (co !== 1'b0) begin
            n_err++;
            $display("FAIL drain_co_stop: got co=%b exp 0", co);
        end
    endtask

    task automatic test_full_pushpop();
        logic [19:0] exp_q [4];
        exp_q[0] = 20'h00002; exp_q[1] = 20'h00003; exp_q[2] = 20'h00004; exp_q[3] = 20'h000AA;
        do_reset();
        for (int i = 1; i <= 4; i++) begin
            datain = 20'(i); in_valid = 1'b1;
            step();
        end
        datain = 20'h000AA; in_valid = 1'b1; out_ready = 1'b1;
        step();
        in_valid = 1'b0; out_ready = 1'b0;
        n_vec++;
        if (level !== 3'd4 || ovf_err !== 1'b0 || co !== 1'b1) begin
            n_err++;
            $display("FAIL full_pushpop: got lvl=%0d ovf=%b co=%b exp lvl=4 ovf=0 co=1",
                     level, ovf_err, co);
        end
        step();
        n_vec++;
        if (co !== 1'b0) begin
            n_err++;
            $display("FAIL full_pushpop_co: got co=%b exp 0", co);
        end
        for (int i = 0; i < 4; i++) begin
            n_vec++;
            if (out_valid !== 1'b1 || dataout !== exp_q[i]) begin
                n_err++;
                $display("FAIL full_drain_%0d: got v=%b dout=%h exp v=1 dout=%h",
                         i, out_valid, dataout, exp_q[i]);
            end
            out_ready = 1'b1;
            step();
        end
        out_ready = 1'b0;
        n_vec++;
        if (out_valid !== 1'b0 || level !== 3'd0) begin
            n_err++;
            $display("FAIL full_drain_end: got v=%b lvl=%0d exp v=0 lvl=0", out_valid, level);
        end
    endtask

    task automatic test_stream();
        int co_cnt = 0;
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            datain = 20'(i); in_valid = 1'b1;
            step();
            if (co === 1'b1) co_cnt++;
            n_vec++;
            if (out_valid !== 1'b1 || dataout !== 20'(i) || level !== 3'd1 || co !== (i > 0)) begin
                n_err++;
                $display("FAIL stream_%0d: got v=%b dout=%h lvl=%0d co=%b exp v=1 dout=%h lvl=1 co=%b",
                         i, out_valid, dataout, level, co, 20'(i), (i > 0));
            end
        end
        in_valid = 1'b0;
        step();
        if (co === 1'b1) co_cnt++;
        n_vec++;
        if (out_valid !== 1'b0 || level !== 3'd0 || co !== 1'b1) begin
            n_err++;
            $display("FAIL stream_tail: got v=%b lvl=%0d co=%b exp v=0 lvl=0 co=1",
                     out_valid, level, co);
        end
        step();
        if (co === 1'b1) co_cnt++;
        out_ready = 1'b0;
        n_vec++;
        if (co_cnt != 10) begin
            n_err++;
            $display("FAIL stream_co_count: got %0d exp 10", co_cnt);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            datain = 20'hC0000 + 20'(i); in_valid = 1'b1;
            step();
        end
        in_valid = 1'b0; out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        n_vec++;
        if (level !== 3'd3 || co !== 1'b1) begin
            n_err++;
            $display("FAIL mid_setup: got lvl=%0d co=%b exp lvl=3 co=1", level, co);
        end
        #2;
        RST = 1'b0;
        #1;
        n_vec++;
        if ({dataout, out_valid, co, level, ovf_err} !== 26'd0) begin
            n_err++;
            $display("FAIL mid_async: got dout=%h v=%b co=%b lvl=%0d ovf=%b exp all 0",
                     dataout, out_valid, co, level, ovf_err);
        end
        #2;
        RST = 1'b1;
        step();
        datain = 20'h0BEEF; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        n_vec++;
        if (out_valid !== 1'b1 || dataout !== 20'h0BEEF || level !== 3'd1) begin
            n_err++;
            $display("FAIL mid_fresh: got v=%b dout=%h lvl=%0d exp v=1 dout=0beef lvl=1",
                     out_valid, dataout, level);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        n_vec++;
        if (out_valid !== 1'b0 || co !== 1'b1) begin
            n_err++;
            $display("FAIL mid_no_stale: got v=%b co=%b exp v=0 co=1", out_valid, co);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_fill_ovf();
        test_full_pushpop();
        test_stream();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
